cell_unit: RTL
==============

CELL_UNIT -- requirements
Module: cell_unit

Interface
REQ-001 SHALL have parameter AW, default 8, giving the data-memory address width (tape length 2**AW cells).
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port op_valid, input, 1 bit: the control unit presents an operation.
REQ-005 SHALL have port op_code, input, 3 bits: the operation; 0 NOP, 1 PTR_INC, 2 PTR_DEC, 3 CELL_INC, 4 CELL_DEC, 5 CELL_LOAD; codes 6 and 7 execute as NOP.
REQ-006 SHALL have port op_data, input, 8 bits: the byte to store for CELL_LOAD.
REQ-007 SHALL have port op_ready, output, 1 bit: the unit accepts an operation this cycle.
REQ-008 SHALL have port done, output, 1 bit: a one-cycle pulse that marks operation completion.
REQ-009 SHALL have port ptr, output, AW bits: the current data pointer.
REQ-010 SHALL have port cell_val, output, 8 bits: a cached copy of mem[ptr].
REQ-011 SHALL have port cell_zero, output, 1 bit: cell_val==0, combinational.
REQ-012 SHALL have port memAddress, output, AW bits: the data-memory address.
REQ-013 SHALL have port ReadMem, output, 1 bit: the data-memory read enable.
REQ-014 SHALL have port WriteMem, output, 1 bit: the data-memory write enable.
REQ-015 SHALL have port memDataIn, output, 8 bits: the write data to the memory.
REQ-016 SHALL have port memDataOut, input, 8 bits: the combinational read data from the memory; valid in the same cycle as ReadMem.

Function
REQ-017 SHALL implement FSM states INIT, IDLE, FETCH, WRITE; op_ready = (state==IDLE).
REQ-018 SHALL treat an op as accepted on a rising edge where state==IDLE and op_valid==1; op_code and op_data are sampled only at that edge.
REQ-019 SHALL transition INIT->FETCH unconditionally, FETCH->IDLE, and WRITE->IDLE.
REQ-020 SHALL execute PTR_INC/PTR_DEC as: at accept, ptr<=ptr±1 modulo 2**AW (255+1->0, 0-1->255 for AW=8), then state<=FETCH.
REQ-021 SHALL, in FETCH, drive ReadMem=1 and memAddress=ptr, and load cell_val<=memDataOut at the closing edge.
REQ-022 SHALL execute CELL_INC/CELL_DEC as: at accept, cell_val<=cell_val±1 modulo 256 (255+1->0, 0-1->255), then state<=WRITE.
REQ-023 SHALL execute CELL_LOAD as: at accept, cell_val<=op_data, then state<=WRITE.
REQ-024 SHALL, in WRITE, drive WriteMem=1, memAddress=ptr and memDataIn=cell_val for exactly one cycle.
REQ-025 SHALL execute NOP (and codes 6, 7) with no memory access: accept->IDLE, done pulsed next cycle.
REQ-026 SHALL make done a registered pulse, high exactly one cycle: for NOP the cycle after accept; for other ops the cycle after FETCH/WRITE ends.
REQ-027 SHALL give ptr ops latency 2 cycles (accept at N, done at N+2), cell ops latency 2, NOP latency 1.
REQ-028 SHALL drive ReadMem=0 and WriteMem=0 in INIT and IDLE, and never assert both in the same cycle.
REQ-029 SHALL drive memAddress=ptr and memDataIn=cell_val in all states.
REQ-030 SHALL let a new op be accepted in the same cycle done is high (back-to-back ops).
REQ-031 SHALL NOT pulse done for the post-reset FETCH.
REQ-032 SHALL ignore op_valid while state!=IDLE; ops are not queued.

Reset
REQ-033 SHALL, on reset, set state=INIT, ptr=0, cell_val=0, done=0; consequently op_ready=0, ReadMem=0, WriteMem=0 and cell_zero=1.
REQ-034 SHALL abandon any in-flight op on reset mid-operation (FETCH or WRITE): WriteMem=0 from the first cycle after the reset edge; no done pulse.
REQ-035 SHALL, after reset deasserts, run INIT (1 cycle) then FETCH of mem[0] (1 cycle), and raise op_ready in the 3rd cycle.

Structure
REQ-036 SHALL place the op_code enum (3-bit), the FSM state enum and the default AW=8 in shared package beef_pkg.
REQ-037 SHALL be a single flat module with no sub-modules; the bench connects it directly to the existing data memory.

Verification
REQ-038 SHALL verify reset with preloaded memory mem[0]=8'h2A: release reset -> op_ready high on 3rd cycle, cell_val=8'h2A, no done pulse.
REQ-039 SHALL verify CELL_INC ×3 back-to-back from mem[0]=8'hFE -> cell_val sequence FF, 00, 01; mem[0]=8'h01; cell_zero high only after the 2nd op.
REQ-040 SHALL verify PTR_DEC from ptr=0 with mem[255]=8'h77 -> ptr=255, ReadMem high 1 cycle at address 255, cell_val=8'h77, done at N+2.
REQ-041 SHALL verify CELL_LOAD op_data=8'h5A, then PTR_INC, then PTR_DEC -> mem[ptr]=8'h5A re-read, cell_val=8'h5A.
REQ-042 SHALL verify NOP and op_code=7 -> done at N+1, ReadMem and WriteMem stay 0, ptr and cell_val unchanged.
REQ-043 SHALL verify reset asserted during WRITE of CELL_INC -> WriteMem low the next cycle, ptr=0, no done pulse, normal INIT/FETCH restart.

Source files
------------

// File: rtl/beef_pkg.sv
// Shared types for the data-cell unit: operation codes, controller states
// and the default tape address width.
package beef_pkg;

  localparam int AW_DEFAULT = 8;

  // Codes 6 and 7 are not listed and execute as NOP.
  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_PTR_INC   = 3'd1,
    OP_PTR_DEC   = 3'd2,
    OP_CELL_INC  = 3'd3,
    OP_CELL_DEC  = 3'd4,
    OP_CELL_LOAD = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FETCH = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/cell_unit.sv
// Data-cell unit: owns the tape pointer and a cached copy of the current
// cell, and sequences single-cycle reads/writes to an external data memory.
//
// state | meaning
// INIT  | one cycle after reset, then fetch mem[0]
// IDLE  | op_ready high, waiting for an operation
// FETCH | ReadMem high, cell_val reloaded from mem[ptr]
// WRITE | WriteMem high, cell_val stored to mem[ptr]
module cell_unit
  import beef_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  input  logic [2:0]    op_code,
  input  logic [7:0]    op_data,
  output logic          op_ready,
  output logic          done,
  output logic [AW-1:0] ptr,
  output logic [7:0]    cell_val,
  output logic          cell_zero,
  output logic [AW-1:0] memAddress,
  output logic          ReadMem,
  output logic          WriteMem,
  output logic [7:0]    memDataIn,
  input  logic [7:0]    memDataOut
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  state_e        state, state_nxt;
  logic [AW-1:0] ptr_nxt;
  logic [7:0]    cell_nxt;
  logic          done_nxt;
  // Set while the FETCH in flight is the post-reset load of mem[0], which
  // must complete silently without a done pulse.
  logic          boot_fetch, boot_nxt;

  // State, pointer, cached cell and done pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_INIT;
      ptr        <= '0;
      cell_val   <= 8'h00;
      done       <= 1'b0;
      boot_fetch <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      cell_val   <= cell_nxt;
      done       <= done_nxt;
      boot_fetch <= boot_nxt;
    end
  end

  // Next-state, operation execution and completion decode.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cell_nxt  = cell_val;
    done_nxt  = 1'b0;
    boot_nxt  = boot_fetch;
    case (state)
      ST_INIT: begin
        state_nxt = ST_FETCH;
        boot_nxt  = 1'b1;
      end
      ST_IDLE: begin
        if (op_valid) begin
          case (op_e'(op_code))
            OP_PTR_INC: begin
              ptr_nxt   = ptr + PTR_ONE;
              state_nxt = ST_FETCH;
              boot_nxt  = 1'b0;
            end
            OP_PTR_DEC: begin
              ptr_nxt   = ptr - PTR_ONE;
              state_nxt = ST_FETCH;
              boot_nxt  = 1'b0;
            end
            OP_CELL_INC: begin
              cell_nxt  = cell_val + 8'd1;
              state_nxt = ST_WRITE;
            end
            OP_CELL_DEC: begin
              cell_nxt  = cell_val - 8'd1;
              state_nxt = ST_WRITE;
            end
            OP_CELL_LOAD: begin
              cell_nxt  = op_data;
              state_nxt = ST_WRITE;
            end
            default: done_nxt = 1'b1;
          endcase
        end
      end
      ST_FETCH: begin
        cell_nxt  = memDataOut;
        done_nxt  = ~boot_fetch;
        boot_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      ST_WRITE: begin
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign op_ready   = (state == ST_IDLE);
  assign ReadMem    = (state == ST_FETCH);
  assign WriteMem   = (state == ST_WRITE);
  assign memAddress = ptr;
  assign memDataIn  = cell_val;
  assign cell_zero  = (cell_val == 8'h00);

endmodule
